// File: rtl/complex_pkg.sv
// Shared constants for the complex add/sub datapath: 64-bit values packed as
// {real[63:32], imag[31:0]}, each half an IEEE-754 single.
package complex_pkg;

  localparam int CPLX_W = 64;
  localparam int HALF_W = 32;

  localparam int RE_MSB = 63;
  localparam int RE_LSB = 32;
  localparam int IM_MSB = 31;
  localparam int IM_LSB = 0;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic [HALF_W-1:0] re;
    logic [HALF_W-1:0] im;
  } cplx_t;

endpackage

// File: rtl/complex_addsub_driver_if.sv
// Operand and result streams of the complex add/sub driver, bundled so the
// producer/consumer side and the driver side see matching directions.
interface complex_addsub_driver_if import complex_pkg::*; ();

  logic              in_valid;
  logic              in_ready;
  logic [CPLX_W-1:0] in_a;
  logic [CPLX_W-1:0] in_b;
  logic              in_op;

  logic              res_valid;
  logic              res_ready;
  logic [CPLX_W-1:0] res_data;

  modport master (
    output in_valid, in_a, in_b, in_op, res_ready,
    input  in_ready, res_valid, res_data
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, res_ready,
    output in_ready, res_valid, res_data
  );

endinterface

// File: rtl/complex_result_fifo.sv
// First-word-fall-through result FIFO; the head entry is always visible on
// pop_data and a pop on a full FIFO frees the slot for a same-cycle push.
module complex_result_fifo import complex_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [CPLX_W-1:0]        push_data,
  input  logic                     pop,
  output logic [CPLX_W-1:0]        pop_data,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [CPLX_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign valid    = (count != '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && valid;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: only entries between rd_ptr and wr_ptr are ever shown.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/complex_addsub_driver.sv
// Initiator-side sequencer for the pipelined complex adder/subtractor: issues
// operands, tracks them through the adder latency and queues the results.
module complex_addsub_driver import complex_pkg::*; #(
  parameter int ADD_LAT    = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  complex_addsub_driver_if.slave   bus,
  output logic [CPLX_W-1:0]        add_a,
  output logic [CPLX_W-1:0]        add_b,
  output logic                     add_op,
  output logic                     add_ce,
  input  logic [CPLX_W-1:0]        add_result,
  output logic                     overflow
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW  = $clog2(FIFO_DEPTH + ADD_LAT + 1) + 1;

  logic [ADD_LAT:0] vld;
  logic             accept;
  logic             capture;
  logic             pop;
  logic             fifo_full;
  logic [FCW-1:0]   fifo_count;
  logic [CW-1:0]    inflight;
  logic [CW-1:0]    used;

  assign accept  = bus.in_valid && bus.in_ready;
  assign capture = vld[ADD_LAT];
  assign pop     = bus.res_valid && bus.res_ready;
  assign add_ce  = |vld[ADD_LAT-1:0];

  // The tag in vld[ADD_LAT] is neither in the adder nor yet in the FIFO, so it
  // must hold a credit too, otherwise one extra op slips in and gets dropped.
  always_comb begin
    inflight = '0;
    for (int k = 0; k <= ADD_LAT; k++) begin
      inflight = inflight + CW'(vld[k]);
    end
    used = inflight + CW'(fifo_count);
  end

  assign bus.in_ready = (used < CW'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a    <= '0;
      add_b    <= '0;
      add_op   <= OP_ADD;
      vld      <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        add_a  <= bus.in_a;
        add_b  <= bus.in_b;
        add_op <= bus.in_op;
      end
      vld <= {vld[ADD_LAT-1:0], accept};
      if (capture && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  complex_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (capture),
    .push_data (add_result),
    .pop       (pop),
    .pop_data  (bus.res_data),
    .valid     (bus.res_valid),
    .full      (fifo_full),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_complex_addsub_driver.sv
// Bench for complex_addsub_driver: an integer-valued float adder stub on the
// adder pins and a queue of expected results computed from the operand values.
module tb_complex_addsub_driver;

  localparam int L = 2;
  localparam int D = 8;

  logic        clk;
  logic        rst_n;
  logic [63:0] add_a;
  logic [63:0] add_b;
  logic        add_op;
  logic        add_ce;
  logic [63:0] add_result;
  logic        overflow;

  complex_addsub_driver_if bus ();

  complex_addsub_driver #(
    .ADD_LAT    (L),
    .FIFO_DEPTH (D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_op     (add_op),
    .add_ce     (add_ce),
    .add_result (add_result),
    .overflow   (overflow)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          n_acc = 0;
  int          n_pop = 0;
  logic [63:0] exp_q[$];
  logic [63:0] pend_a, pend_b, pend_exp;
  logic        pend_op;
  logic [63:0] last_a, last_b;
  logic        last_op;
  logic [63:0] pipe [L];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] int_to_f32(input int v);
    int          m;
    int          p;
    logic [31:0] r;
    if (v == 0) return 32'h0;
    m = (v < 0) ? -v : v;
    p = 0;
    for (int k = 0; k < 31; k++) if (m[k]) p = k;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + p);
    r[22:0]  = 23'(m << (23 - p));
    return r;
  endfunction

  function automatic int f32_to_int(input logic [31:0] f);
    int e;
    int m;
    int v;
    e = int'(f[30:23]);
    if (e == 0) return 0;
    m = int'({1'b1, f[22:0]});
    v = (e >= 150) ? (m << (e - 150)) : (m >> (150 - e));
    return f[31] ? -v : v;
  endfunction

  function automatic logic [63:0] stub_add(input logic [63:0] a, input logic [63:0] b, input logic op);
    int re;
    int im;
    re = op ? f32_to_int(a[63:32]) - f32_to_int(b[63:32]) : f32_to_int(a[63:32]) + f32_to_int(b[63:32]);
    im = op ? f32_to_int(a[31:0]) - f32_to_int(b[31:0]) : f32_to_int(a[31:0]) + f32_to_int(b[31:0]);
    return {int_to_f32(re), int_to_f32(im)};
  endfunction

  // Adder model: L-stage pipeline that only advances on ce.
  always @(posedge clk) begin
    if (add_ce) begin
      pipe[0] <= stub_add(add_a, add_b, add_op);
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign add_result = pipe[L-1];

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic make_op(input logic op);
    int ra, ia, rb, ib;
    ra = int'($urandom_range(2000)) - 1000;
    ia = int'($urandom_range(2000)) - 1000;
    rb = int'($urandom_range(2000)) - 1000;
    ib = int'($urandom_range(2000)) - 1000;
    pend_a   = {int_to_f32(ra), int_to_f32(ia)};
    pend_b   = {int_to_f32(rb), int_to_f32(ib)};
    pend_op  = op;
    pend_exp = op ? {int_to_f32(ra - rb), int_to_f32(ia - ib)}
                  : {int_to_f32(ra + rb), int_to_f32(ia + ib)};
  endtask

  task automatic apply_stimulus(input logic valid, input logic rdy);
    bus.in_valid  = valid;
    bus.in_a      = pend_a;
    bus.in_b      = pend_b;
    bus.in_op     = pend_op;
    bus.res_ready = rdy;
  endtask

  // Scoreboard update for the current cycle, then advance to #1 after the edge.
  task automatic step();
    if (bus.in_valid && bus.in_ready) begin
      exp_q.push_back(pend_exp);
      n_acc++;
      last_a  = pend_a;
      last_b  = pend_b;
      last_op = pend_op;
    end
    if (bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) begin
        check_output("res_spurious", 64'(bus.res_valid), 64'd0);
      end else begin
        check_output("res_data", bus.res_data, exp_q.pop_front());
        n_pop++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) step();
    check_output(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int acc0, pop0, idx;

    rst_n = 1'b0;
    pend_a = '0; pend_b = '0; pend_op = 1'b0; pend_exp = '0;
    apply_stimulus(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_add_a", add_a, 64'd0);
    check_output("rst_add_b", add_b, 64'd0);
    check_output("rst_add_op", 64'(add_op), 64'd0);
    check_output("rst_add_ce", 64'(add_ce), 64'd0);
    check_output("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check_output("rst_res_data", bus.res_data, 64'd0);
    check_output("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_output("rst_overflow", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    step();

    $display("[TB] single op");
    pend_a   = 64'h3F800000_40000000;
    pend_b   = 64'h3F800000_3F800000;
    pend_op  = 1'b0;
    pend_exp = 64'h40000000_40400000;
    apply_stimulus(1'b1, 1'b0);
    step();
    apply_stimulus(1'b0, 1'b0);
    check_output("single_add_ce", 64'(add_ce), 64'd1);
    check_output("single_add_a", add_a, 64'h3F800000_40000000);
    check_output("single_add_b", add_b, 64'h3F800000_3F800000);
    check_output("single_add_op", 64'(add_op), 64'd0);
    check_output("single_lat0", 64'(bus.res_valid), 64'd0);
    for (int i = 1; i <= L + 1; i++) begin
      step();
      check_output("single_latency", 64'(bus.res_valid), 64'(i == L + 1));
    end
    check_output("single_data", bus.res_data, 64'h40000000_40400000);
    apply_stimulus(1'b0, 1'b1);
    step();
    check_output("single_after_pop", 64'(bus.res_valid), 64'd0);

    $display("[TB] streaming");
    pop0 = n_pop;
    for (int i = 0; i < 32; i++) begin
      make_op(1'(i % 2));
      apply_stimulus(1'b1, 1'b1);
      check_output("stream_in_ready", 64'(bus.in_ready), 64'd1);
      if (i > 0) check_output("stream_add_ce", 64'(add_ce), 64'd1);
      step();
    end
    apply_stimulus(1'b0, 1'b1);
    drain("stream_drain");
    check_output("stream_count", 64'(n_pop - pop0), 64'd32);

    $display("[TB] backpressure");
    acc0 = n_acc;
    pop0 = n_pop;
    idx  = 0;
    make_op(1'($urandom_range(1)));
    for (int c = 0; c < 20; c++) begin
      apply_stimulus(1'b1, 1'b0);
      step();
      if (n_acc - acc0 > idx) begin
        idx++;
        make_op(1'($urandom_range(1)));
      end
    end
    check_output("bp_accepted", 64'(n_acc - acc0), 64'd8);
    check_output("bp_in_ready", 64'(bus.in_ready), 64'd0);
    check_output("bp_overflow", 64'(overflow), 64'd0);
    check_output("bp_res_valid", 64'(bus.res_valid), 64'd1);
    for (int c = 0; c < 60 && !(idx == 12 && exp_q.size() == 0); c++) begin
      apply_stimulus(idx < 12, 1'b1);
      step();
      if (n_acc - acc0 > idx) begin
        idx++;
        make_op(1'($urandom_range(1)));
      end
    end
    check_output("bp_total_accepted", 64'(n_acc - acc0), 64'd12);
    check_output("bp_total_popped", 64'(n_pop - pop0), 64'd12);
    check_output("bp_overflow_end", 64'(overflow), 64'd0);

    $display("[TB] idle");
    apply_stimulus(1'b0, 1'b1);
    repeat (10) step();
    check_output("idle_add_ce", 64'(add_ce), 64'd0);
    check_output("idle_add_a", add_a, last_a);
    check_output("idle_add_b", add_b, last_b);
    check_output("idle_add_op", 64'(add_op), 64'(last_op));

    $display("[TB] random traffic");
    acc0 = n_acc;
    pop0 = n_pop;
    for (int c = 0; c < 80; c++) begin
      make_op(1'($urandom_range(1)));
      apply_stimulus(1'($urandom_range(1)), 1'($urandom_range(3) != 0));
      step();
    end
    apply_stimulus(1'b0, 1'b1);
    drain("rand_drain");
    check_output("rand_balance", 64'(n_pop - pop0), 64'(n_acc - acc0));
    check_output("rand_overflow", 64'(overflow), 64'd0);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 7; i++) begin
      make_op(1'(i % 2));
      apply_stimulus(1'b1, 1'b0);
      step();
    end
    apply_stimulus(1'b0, 1'b0);
    check_output("mid_res_valid_pre", 64'(bus.res_valid), 64'd1);
    check_output("mid_add_ce_pre", 64'(add_ce), 64'd1);
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_res_valid", 64'(bus.res_valid), 64'd0);
    check_output("mid_rst_res_data", bus.res_data, 64'd0);
    check_output("mid_rst_add_ce", 64'(add_ce), 64'd0);
    check_output("mid_rst_add_a", add_a, 64'd0);
    check_output("mid_rst_add_b", add_b, 64'd0);
    check_output("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_output("mid_rst_overflow", 64'(overflow), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply_stimulus(1'b0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      step();
      check_output("mid_no_stale", 64'(bus.res_valid), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
